// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Central pipeline sequencer for the 5-stage RV64 core.
//                Produces IF/ID/EX stall, flush and bubble controls, detects
//                load-use hazards, applies branch flushes and runs the ecall
//                drain / host hand-off / resume sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int REGW      = 5,
  parameter int DRAIN_MAX = 16,
  parameter int CNTW      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_uses_rs2,
  input  logic            id_is_ecall,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic [REGW-1:0] ex_rd,
  input  logic            mem_valid,
  input  logic            wb_valid,
  input  logic            ex_branch_taken,
  input  logic            ecall_ack,
  input  logic            ecall_done,
  output logic            if_stall,
  output logic            id_stall,
  output logic            id_flush,
  output logic            ex_bubble,
  output logic            ecall_req,
  output logic            ecall_busy,
  output logic            drain_err,
  output logic [CNTW-1:0] stall_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRAIN  = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESUME = 3'd4;

  // Drain counter only needs to reach DRAIN_MAX-1.
  localparam int             DCW        = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX - 1);

  logic [2:0]     state;
  logic [2:0]     state_nxt;
  logic [DCW-1:0] drain_cnt;
  logic           lu;
  logic           pipe_empty;
  logic           ecall_entry;
  logic           drain_timeout;

  // x0 never carries a real dependency, so a load to x0 cannot cause a hazard.
  assign lu = id_valid & ex_valid & ex_is_load & (ex_rd != '0) &
              ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

  assign pipe_empty    = ~(ex_valid | mem_valid | wb_valid);
  // A taken branch flushes the ecall out of ID, so it must not start the FSM.
  assign ecall_entry   = id_valid & id_is_ecall & ~ex_branch_taken;
  assign drain_timeout = (state == S_DRAIN) & ~pipe_empty & (drain_cnt == DRAIN_LAST);

  // Control outputs: decoded from state, with the hazard path purely combinational.
  always_comb begin
    if_stall   = 1'b0;
    id_stall   = 1'b0;
    id_flush   = 1'b0;
    ex_bubble  = 1'b0;
    ecall_busy = 1'b0;
    if (!reset) begin
      ecall_busy = (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (ex_branch_taken) begin
            id_flush  = 1'b1;
            ex_bubble = 1'b1;
          end else if (ecall_entry || lu) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_bubble = 1'b1;
          end
        end
        S_DRAIN, S_REQ, S_WAIT: begin
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_bubble = 1'b1;
        end
        S_RESUME: begin
          // Retire the ecall as a NOP and let IF advance again.
          id_flush  = 1'b1;
          ex_bubble = 1'b1;
        end
        default: begin
          if_stall = 1'b0;
        end
      endcase
    end
  end

  // Next-state selection for the ecall sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (ecall_entry) state_nxt = S_DRAIN;
      S_DRAIN:  if (pipe_empty || drain_timeout) state_nxt = S_REQ;
      S_REQ:    if (ecall_ack) state_nxt = ecall_done ? S_RESUME : S_WAIT;
      S_WAIT:   if (ecall_done) state_nxt = S_RESUME;
      S_RESUME: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State, drain counter, host request, sticky error and stall statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      drain_cnt   <= '0;
      drain_err   <= 1'b0;
      ecall_req   <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;

      if (state == S_IDLE) begin
        drain_cnt <= '0;
      end else if ((state == S_DRAIN) && !pipe_empty && !drain_timeout) begin
        drain_cnt <= drain_cnt + DCW'(1);
      end

      if (drain_timeout) begin
        drain_err <= 1'b1;
      end

      // Request rises one cycle into REQ and drops on the edge that samples ack.
      ecall_req <= (state == S_REQ) && !ecall_ack;

      if (if_stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNTW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl: directed scenarios with
//                literal expectations followed by randomized traffic compared
//                against a behavioural model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int REGW      = 5;
  localparam int DRAIN_MAX = 16;
  localparam int CNTW      = 8;
  localparam int SC_MAX    = (1 << CNTW) - 1;

  localparam int PH_IDLE   = 0;
  localparam int PH_DRAIN  = 1;
  localparam int PH_REQ    = 2;
  localparam int PH_WAIT   = 3;
  localparam int PH_RESUME = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid;
  logic [REGW-1:0] id_rs1;
  logic [REGW-1:0] id_rs2;
  logic            id_uses_rs2;
  logic            id_is_ecall;
  logic            ex_valid;
  logic            ex_is_load;
  logic [REGW-1:0] ex_rd;
  logic            mem_valid;
  logic            wb_valid;
  logic            ex_branch_taken;
  logic            ecall_ack;
  logic            ecall_done;
  logic            if_stall;
  logic            id_stall;
  logic            id_flush;
  logic            ex_bubble;
  logic            ecall_req;
  logic            ecall_busy;
  logic            drain_err;
  logic [CNTW-1:0] stall_count;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.REGW(REGW), .DRAIN_MAX(DRAIN_MAX), .CNTW(CNTW)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs2     (id_uses_rs2),
    .id_is_ecall     (id_is_ecall),
    .ex_valid        (ex_valid),
    .ex_is_load      (ex_is_load),
    .ex_rd           (ex_rd),
    .mem_valid       (mem_valid),
    .wb_valid        (wb_valid),
    .ex_branch_taken (ex_branch_taken),
    .ecall_ack       (ecall_ack),
    .ecall_done      (ecall_done),
    .if_stall        (if_stall),
    .id_stall        (id_stall),
    .id_flush        (id_flush),
    .ex_bubble       (ex_bubble),
    .ecall_req       (ecall_req),
    .ecall_busy      (ecall_busy),
    .drain_err       (drain_err),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_phase   = PH_IDLE;
  int m_drained = 0;   // non-empty cycles already spent draining
  int m_req_age = 0;   // cycles already spent in the request phase
  bit m_err     = 1'b0;
  int m_sc      = 0;
  bit mvalid    = 1'b0;

  // {if_stall, id_stall, id_flush, ex_bubble, ecall_busy}
  function automatic logic [4:0] exp_comb();
    logic hz;
    logic ifs, ids, flu, bub;
    hz  = id_valid && ex_valid && ex_is_load && (ex_rd != 0) &&
          ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    ifs = 1'b0; ids = 1'b0; flu = 1'b0; bub = 1'b0;
    if (reset) return 5'b0;
    if (m_phase == PH_IDLE) begin
      if (ex_branch_taken) begin
        flu = 1'b1; bub = 1'b1;
      end else if ((id_valid && id_is_ecall) || hz) begin
        ifs = 1'b1; ids = 1'b1; bub = 1'b1;
      end
    end else if (m_phase == PH_RESUME) begin
      flu = 1'b1; bub = 1'b1;
    end else begin
      ifs = 1'b1; ids = 1'b1; bub = 1'b1;
    end
    return {ifs, ids, flu, bub, (m_phase != PH_IDLE)};
  endfunction

  function automatic bit exp_if_stall();
    logic [4:0] v;
    v = exp_comb();
    return v[4];
  endfunction

  // Model update on the same edge the DUT samples.
  always @(posedge clk) begin
    if (reset) begin
      m_phase   <= PH_IDLE;
      m_drained <= 0;
      m_req_age <= 0;
      m_err     <= 1'b0;
      m_sc      <= 0;
      mvalid    <= 1'b1;
    end else begin
      if (exp_if_stall() && (m_sc < SC_MAX)) m_sc <= m_sc + 1;
      case (m_phase)
        PH_IDLE: if (!ex_branch_taken && id_valid && id_is_ecall) begin
          m_phase   <= PH_DRAIN;
          m_drained <= 0;
        end
        PH_DRAIN: begin
          if (!(ex_valid || mem_valid || wb_valid)) begin
            m_phase   <= PH_REQ;
            m_req_age <= 0;
          end else if (m_drained + 1 == DRAIN_MAX) begin
            m_err     <= 1'b1;
            m_phase   <= PH_REQ;
            m_req_age <= 0;
          end else begin
            m_drained <= m_drained + 1;
          end
        end
        PH_REQ: begin
          m_req_age <= m_req_age + 1;
          if (ecall_ack) m_phase <= ecall_done ? PH_RESUME : PH_WAIT;
        end
        PH_WAIT:   if (ecall_done) m_phase <= PH_RESUME;
        default:   m_phase <= PH_IDLE;
      endcase
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [4:0] e;
    e = exp_comb();
    chk("if_stall",    32'(if_stall),   32'(e[4]));
    chk("id_stall",    32'(id_stall),   32'(e[3]));
    chk("id_flush",    32'(id_flush),   32'(e[2]));
    chk("ex_bubble",   32'(ex_bubble),  32'(e[1]));
    chk("ecall_busy",  32'(ecall_busy), 32'(e[0]));
    chk("ecall_req",   32'(ecall_req),  32'((m_phase == PH_REQ) && (m_req_age >= 1)));
    chk("drain_err",   32'(drain_err),  32'(m_err));
    chk("stall_count", 32'(stall_count), 32'(m_sc));
  endtask

  // One cycle: compare at the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    if (mvalid) compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic quiet();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; id_is_ecall = 0;
    ex_valid = 0; ex_is_load = 0; ex_rd = 0; mem_valid = 0; wb_valid = 0;
    ex_branch_taken = 0; ecall_ack = 0; ecall_done = 0;
  endtask

  task automatic do_reset();
    reset = 1; ticks(2); reset = 0;
  endtask

  // Ecall entry with an empty pipeline: one entry cycle, one DRAIN cycle.
  task automatic enter_ecall_empty();
    id_valid = 1; id_is_ecall = 1; tick();
    id_valid = 0; id_is_ecall = 0; tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    quiet();
    do_reset();
    tick();
    chk("rst_stall_count", 32'(stall_count), 0);
    chk("rst_ecall_req",   32'(ecall_req), 0);
    chk("rst_busy",        32'(ecall_busy), 0);

    // Load-use hazard variants
    ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_valid = 1; id_rs1 = 5;
    #1 chk("lu_rs1_stall", 32'({if_stall, id_stall, ex_bubble}), 32'h7);
    tick();
    ex_rd = 0; id_rs1 = 0;
    #1 chk("lu_rd0_nostall", 32'(if_stall), 0);
    tick();
    ex_rd = 5; id_rs1 = 3; id_rs2 = 5; id_uses_rs2 = 0;
    #1 chk("lu_rs2_unused", 32'(if_stall), 0);
    tick();
    id_uses_rs2 = 1;
    #1 chk("lu_rs2_used", 32'(if_stall), 1);
    tick();
    // Branch wins over a simultaneous hazard
    ex_branch_taken = 1;
    #1 chk("br_over_lu", 32'({id_flush, ex_bubble, if_stall, id_stall}), 32'hC);
    tick();
    quiet();

    // Nominal ecall: 3 DRAIN cycles, 2 REQ, 10 WAIT => 16 stall cycles
    do_reset();
    id_valid = 1; id_is_ecall = 1; ex_valid = 1; mem_valid = 1; wb_valid = 1;
    tick();
    id_valid = 0; id_is_ecall = 0;
    ticks(2);
    ex_valid = 0; mem_valid = 0; wb_valid = 0;
    tick();
    chk("nom_req_first", 32'(ecall_req), 0);
    tick();
    chk("nom_req_rise", 32'(ecall_req), 1);
    ecall_ack = 1; tick(); ecall_ack = 0;
    chk("nom_req_drop", 32'(ecall_req), 0);
    ticks(9);
    ecall_done = 1; tick(); ecall_done = 0;
    #1 chk("nom_resume", 32'({id_flush, ex_bubble, if_stall, id_stall}), 32'hC);
    tick();
    chk("nom_idle", 32'(ecall_busy), 0);
    chk("nom_stall_count", 32'(stall_count), 16);

    // Done before ack is ignored; ack+done together skip WAIT
    enter_ecall_empty();
    ecall_done = 1; tick(); ecall_done = 0;
    chk("early_done_req", 32'(ecall_req), 1);
    ecall_ack = 1; ecall_done = 1; tick(); ecall_ack = 0; ecall_done = 0;
    #1 chk("ackdone_resume", 32'(id_flush), 1);
    tick();
    chk("ackdone_idle", 32'(ecall_busy), 0);

    // Drain timeout with MEM stuck
    mem_valid = 1;
    id_valid = 1; id_is_ecall = 1; tick(); id_valid = 0; id_is_ecall = 0;
    ticks(DRAIN_MAX);
    chk("to_err", 32'(drain_err), 1);
    tick();
    chk("to_req", 32'(ecall_req), 1);
    mem_valid = 0;
    ecall_ack = 1; ecall_done = 1; tick(); ecall_ack = 0; ecall_done = 0;
    tick();
    chk("to_err_sticky", 32'(drain_err), 1);

    // Reset in WAIT, then a fresh ecall
    enter_ecall_empty();
    ecall_ack = 1; tick(); ecall_ack = 0;
    ticks(3);
    reset = 1; tick(); reset = 0;
    tick();
    chk("wrst_sc", 32'(stall_count), 0);
    chk("wrst_busy", 32'(ecall_busy), 0);
    chk("wrst_err", 32'(drain_err), 0);
    enter_ecall_empty();
    tick();
    ecall_ack = 1; tick(); ecall_ack = 0;
    ecall_done = 1; tick(); ecall_done = 0;
    tick();
    chk("fresh_idle", 32'(ecall_busy), 0);

    // Saturation of the stall counter
    enter_ecall_empty();
    ecall_ack = 1; tick(); ecall_ack = 0;
    ticks(SC_MAX + 20);
    chk("sat_hold", 32'(stall_count), SC_MAX);
    ecall_done = 1; tick(); ecall_done = 0;
    ticks(2);
    chk("sat_after", 32'(stall_count), SC_MAX);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      reset           = ($urandom_range(0, 299) == 0);
      id_valid        = ($urandom_range(0, 3) != 0);
      id_rs1          = REGW'($urandom_range(0, 3));
      id_rs2          = REGW'($urandom_range(0, 3));
      id_uses_rs2     = $urandom_range(0, 1);
      id_is_ecall     = ($urandom_range(0, 19) == 0);
      ex_valid        = $urandom_range(0, 1);
      ex_is_load      = $urandom_range(0, 1);
      ex_rd           = REGW'($urandom_range(0, 3));
      mem_valid       = ($urandom_range(0, 2) == 0);
      wb_valid        = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      ecall_ack       = ($urandom_range(0, 3) == 0);
      ecall_done      = ($urandom_range(0, 4) == 0);
      tick();
    end
    quiet();
    reset = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV64 core. It generates stall, flush and bubble controls for the IF, ID and EX boundaries. It detects load-use hazards and applies branch flushes. It runs the ecall sequence: drain the pipeline, hand off to the host, wait for completion, then resume. The decode stage consumes its if_stall, id_stall, id_flush and ex_bubble outputs in place of locally generated stall logic.

Parameters:
REGW, 5, register index width
DRAIN_MAX, 16, maximum cycles spent in DRAIN before forced progress
CNTW, 32, width of the stall performance counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a valid instruction
id_rs1  in  REGW  ID source register 1
id_rs2  in  REGW  ID source register 2
id_uses_rs2  in  1  ID instruction reads rs2
id_is_ecall  in  1  ID instruction is ecall (32'h00000073)
ex_valid  in  1  EX stage occupied
ex_is_load  in  1  EX instruction is a load
ex_rd  in  REGW  EX destination register
mem_valid  in  1  MEM stage occupied
wb_valid  in  1  WB stage occupied
ex_branch_taken  in  1  EX resolved a taken branch or jump
ecall_ack  in  1  host accepted ecall_req
ecall_done  in  1  host finished the ecall
if_stall  out  1  hold PC and IF/ID
id_stall  out  1  hold ID/EX input latch
id_flush  out  1  replace the IF/ID instruction with a NOP (32'h00000013)
ex_bubble  out  1  inject a NOP into EX
ecall_req  out  1  registered request to the host
ecall_busy  out  1  FSM is not in IDLE
drain_err  out  1  sticky flag: DRAIN timed out
stall_count  out  CNTW  cycles with if_stall=1, saturating

Behaviour:
- Synchronous reset, active-high, on clk. Reset puts the FSM in IDLE and clears drain counter, drain_err, stall_count and ecall_req. While reset is high, all combinational outputs are forced to 0.
- States: IDLE, DRAIN, REQ, WAIT, RESUME. ecall_busy = (state != IDLE).
- Load-use hazard, lu, is true when all of these hold: id_valid, ex_valid, ex_is_load, ex_rd != 0, and either ex_rd == id_rs1 or (id_uses_rs2 and ex_rd == id_rs2).
- Output priority in IDLE is reset > branch > ecall entry > lu > none:
  - branch (ex_branch_taken=1): id_flush=1, ex_bubble=1, if_stall=0, id_stall=0. An ecall in ID during this cycle is flushed and does not start the FSM.
  - ecall entry (id_valid & id_is_ecall): if_stall=1, id_stall=1, ex_bubble=1; next state is DRAIN and the drain counter is cleared.
  - lu: if_stall=1, id_stall=1, ex_bubble=1, for exactly one cycle per hazard. The combinational path to outputs has no added latency.
- DRAIN: if_stall=1, id_stall=1, ex_bubble=1.
  - If ex_valid, mem_valid and wb_valid are all 0, go to REQ.
  - Otherwise the drain counter increments. When it reaches DRAIN_MAX-1 with the pipeline still not empty, set drain_err (sticky) and go to REQ.
  - ex_branch_taken is ignored in DRAIN; it cannot occur behind an ecall.
- REQ: stalls held. ecall_req is registered and goes to 1 on the cycle after entry; it stays 1 until ecall_ack is sampled high.
  - ecall_ack without ecall_done: go to WAIT.
  - ecall_ack with ecall_done in the same cycle: go to RESUME.
  - ecall_done without ecall_ack: ignored.
  - ecall_req drops at the edge where ack is sampled.
- WAIT: stalls held; ecall_req=0. Go to RESUME when ecall_done=1.
- RESUME: exactly one cycle with if_stall=0, id_stall=0, id_flush=1, ex_bubble=1. This retires the ecall as a NOP and lets IF advance. Next state is IDLE.
- stall_count increments on every cycle with if_stall=1 and saturates at 2^CNTW-1 (no wrap).
- Reset asserted mid-sequence, including during REQ with ecall_req high, returns to IDLE. ecall_req is 0 in the first cycle after reset deasserts.

Test Plan:
- Load-use: EX ld with ex_rd=5, ID add with id_rs1=5 → if_stall=id_stall=ex_bubble=1 for 1 cycle. Repeat with ex_rd=0 → no stall. Repeat with id_rs2=5 and id_uses_rs2=0 → no stall.
- Branch vs hazard: lu condition and ex_branch_taken=1 in the same cycle → id_flush=1, ex_bubble=1, if_stall=0.
- Ecall nominal: ecall in ID with ex/mem/wb valid draining over 3 cycles → DRAIN lasts 3 cycles, ecall_req rises next. ack after 2 cycles, done 10 cycles later → RESUME pulses id_flush for 1 cycle, then IDLE. stall_count = 16.
- Ack and done together in REQ → direct REQ→RESUME, WAIT is never entered. Done before ack → ignored; ecall_req stays high.
- Drain timeout: mem_valid stuck at 1 → after 16 DRAIN cycles, drain_err=1 and ecall_req=1. drain_err stays 1 after the sequence completes.
- Reset during WAIT → IDLE, all outputs 0, stall_count=0. A fresh ecall afterwards completes normally. Force stall_count to all-ones → it stays at all-ones.
